ptmch_trg_sched: RTL

Trigger-pulse sequencer for the pattern-match trigger path. It takes decoded register writes from the SPI slave and holds per-channel delay and width settings. On a start command it runs one timed sequence that drives the five TRG_PLS outputs, each pulse offset from a common start instant. It sits between the SPI register decoder and the trigger output pins, all in the CLK160M domain.

---
 rtl/ptmch_trg_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ptmch_trg_sched.sv
// Trigger-pulse sequencer: per-channel delay/width registers, one timed pulse run per START.
// Build macro PTMCH_REPEAT_EN adds a repeat-count register at address 11 (REP+1 passes per run).
module ptmch_trg_sched #(
  parameter int NCH = 5,
  parameter int DW  = 16,
  parameter int WW  = 8
) (
  input  logic           CLK160M,
  input  logic           RESET_N,
  input  logic           WR_EN,
  input  logic [3:0]     WR_ADDR,
  input  logic [15:0]    WR_DATA,
  output logic [NCH-1:0] TRG_PLS,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR
);
  localparam int CW = DW + 1;
  localparam logic [3:0] ADDR_CTRL = 4'd10;
`ifdef PTMCH_REPEAT_EN
  localparam logic [3:0] ADDR_REP = 4'd11;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_e;
  state_e state_q, state_d;

  logic [DW-1:0]  dly_q [NCH];
  logic [DW-1:0]  dly_s_q [NCH];
  logic [WW-1:0]  wid_q [NCH];
  logic [WW-1:0]  wid_s_q [NCH];
  logic [NCH-1:0] mask_q, mask_s_q;
  logic [CW-1:0]  end_live [NCH];
  logic [CW-1:0]  end_shd [NCH];
  logic [CW-1:0]  last_calc, last_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] trg_q, trg_d;
  logic           err_q, err_d;
  logic           wr_ctrl, start, abort, err_clr;
`ifdef PTMCH_REPEAT_EN
  logic [7:0]     rep_q, rep_rem_q, rep_rem_d;
`endif

  // WR_EN is a one-cycle strobe with no backpressure: WR_ADDR/WR_DATA are only
  // meaningful while WR_EN=1, and every strobed write is taken on that edge.
  always_comb begin
    wr_ctrl = WR_EN && (WR_ADDR == ADDR_CTRL);
    start   = wr_ctrl && WR_DATA[0];
    abort   = wr_ctrl && WR_DATA[1];
    err_clr = wr_ctrl && WR_DATA[7];
  end

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        dly_q[i] <= '0;
        wid_q[i] <= '0;
      end
      mask_q <= '0;
`ifdef PTMCH_REPEAT_EN
      rep_q  <= '0;
`endif
    end else if (WR_EN) begin
      for (int i = 0; i < NCH; i++) begin
        if (WR_ADDR == 4'(i))       dly_q[i] <= WR_DATA[DW-1:0];
        if (WR_ADDR == 4'(NCH + i)) wid_q[i] <= WR_DATA[WW-1:0];
      end
      if (WR_ADDR == ADDR_CTRL) mask_q <= WR_DATA[2 +: NCH];
`ifdef PTMCH_REPEAT_EN
      if (WR_ADDR == ADDR_REP)  rep_q  <= WR_DATA[7:0];
`endif
    end
  end

  // End points are 17 bits wide so DLY=0xFFFF plus WID=0xFF cannot wrap.
  always_comb begin
    last_calc = '0;
    for (int i = 0; i < NCH; i++) begin
      end_live[i] = {1'b0, dly_q[i]} + CW'(wid_q[i]);
      end_shd[i]  = {1'b0, dly_s_q[i]} + CW'(wid_s_q[i]);
      if (mask_q[i] && (wid_q[i] != '0) && (end_live[i] > last_calc))
        last_calc = end_live[i];
    end
  end

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        dly_s_q[i] <= '0;
        wid_s_q[i] <= '0;
      end
      mask_s_q <= '0;
      last_q   <= '0;
    end else if (state_q == S_ARM) begin
      for (int i = 0; i < NCH; i++) begin
        dly_s_q[i] <= dly_q[i];
        wid_s_q[i] <= wid_q[i];
      end
      mask_s_q <= mask_q;
      last_q   <= last_calc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trg_d   = '0;
    err_d   = err_q;
`ifdef PTMCH_REPEAT_EN
    rep_rem_d = rep_rem_q;
`endif
    // Clear is applied first so a START landing while busy still flags the error.
    if (err_clr) err_d = 1'b0;
    if (start && BUSY && !abort) err_d = 1'b1;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_RUN;
`ifdef PTMCH_REPEAT_EN
        rep_rem_d = rep_q;
`endif
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == last_q) begin
`ifdef PTMCH_REPEAT_EN
          if (rep_rem_q != 8'd0) begin
            rep_rem_d = rep_rem_q - 8'd1;
            cnt_d     = '0;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          for (int i = 0; i < NCH; i++)
            trg_d[i] = mask_s_q[i] && (cnt_q >= {1'b0, dly_s_q[i]}) && (cnt_q < end_shd[i]);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      trg_q   <= '0;
      err_q   <= 1'b0;
`ifdef PTMCH_REPEAT_EN
      rep_rem_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trg_q   <= trg_d;
      err_q   <= err_d;
`ifdef PTMCH_REPEAT_EN
      rep_rem_q <= rep_rem_d;
`endif
    end
  end

  assign TRG_PLS = trg_q;
  assign BUSY    = (state_q == S_ARM) || (state_q == S_RUN);
  assign DONE    = (state_q == S_DONE);
  assign ERR     = err_q;

endmodule
